// File: rtl/cart_load_ctrl.sv
// Cartridge ROM loader: ioctl bytes -> SDRAM writes + detector strobe, then config capture and core reset release.
// Latency: 1 cycle ioctl_wr->mem_req, 1 cycle mem_ack->rom_we; holds ioctl_wait while a write is outstanding. Option: CART_MAPPER_OVERRIDE_EN.
module cart_load_ctrl #(
    parameter logic [24:0] BASE_ADDR     = 25'h0000000,
    parameter int          SETTLE_CYCLES = 4,
    parameter int          RESET_HOLD    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_isROM,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [24:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        rom_we,
    output logic [24:0] rom_addr,
    output logic [7:0]  rom_dout,
    input  logic [2:0]  det_mapper,
    input  logic [3:0]  det_offset,
    input  logic [24:0] det_size,
`ifdef CART_MAPPER_OVERRIDE_EN
    input  logic [2:0]  override_mapper,
`endif
    output logic [2:0]  cfg_mapper,
    output logic [3:0]  cfg_offset,
    output logic [24:0] cfg_size,
    output logic        cfg_valid,
    output logic        cart_reset,
    output logic        err_overrun
);

    typedef enum logic [2:0] {IDLE, LOAD, WRITE, SETTLE, HOLD} state_t;

    state_t      state, state_next;
    logic        isrom_q;
    logic [24:0] byte_cnt;
    logic [15:0] cnt;
    logic        rise, restart, settle_done, hold_done;
    logic [2:0]  cap_mapper;
    logic [3:0]  cap_offset;

    assign rise        = ioctl_isROM & ~isrom_q;
    assign restart     = rise && (state == IDLE || state == SETTLE || state == HOLD);
    assign settle_done = (cnt == 16'(SETTLE_CYCLES - 1));
    assign hold_done   = (cnt == 16'(RESET_HOLD - 1));

`ifdef CART_MAPPER_OVERRIDE_EN
    assign cap_mapper = (override_mapper != 3'd0) ? override_mapper : det_mapper;
    assign cap_offset = (override_mapper != 3'd0) ? 4'd0 : det_offset;
`else
    assign cap_mapper = det_mapper;
    assign cap_offset = det_offset;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (rise) state_next = LOAD;
            LOAD: begin
                if (ioctl_wr)          state_next = WRITE;
                else if (!ioctl_isROM) state_next = SETTLE;
            end
            WRITE:  if (mem_ack) state_next = LOAD;
            SETTLE: begin
                if (rise)             state_next = LOAD;
                else if (settle_done) state_next = HOLD;
            end
            HOLD: begin
                if (rise)           state_next = LOAD;
                else if (hold_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            isrom_q     <= 1'b0;
            byte_cnt    <= '0;
            cnt         <= '0;
            ioctl_wait  <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            mem_din     <= '0;
            rom_we      <= 1'b0;
            rom_addr    <= '0;
            rom_dout    <= '0;
            cfg_mapper  <= '0;
            cfg_offset  <= '0;
            cfg_size    <= '0;
            cfg_valid   <= 1'b0;
            cart_reset  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            isrom_q <= ioctl_isROM;
            rom_we  <= 1'b0;

            case (state)
                SETTLE:  cnt <= settle_done ? 16'd0 : cnt + 16'd1;
                HOLD:    cnt <= cnt + 16'd1;
                default: cnt <= '0;
            endcase

            if (state == LOAD && ioctl_wr) begin
                rom_addr   <= ioctl_addr;
                rom_dout   <= ioctl_dout;
                mem_addr   <= BASE_ADDR + ioctl_addr;
                mem_din    <= ioctl_dout;
                mem_req    <= 1'b1;
                ioctl_wait <= 1'b1;
            end

            if (state == WRITE) begin
                // a strobe while a byte is pending is dropped, only flagged
                if (ioctl_wr) err_overrun <= 1'b1;
                if (mem_ack) begin
                    mem_req    <= 1'b0;
                    ioctl_wait <= 1'b0;
                    rom_we     <= 1'b1;
                    if (byte_cnt != '1) byte_cnt <= byte_cnt + 25'd1;
                end
            end

            if (state == SETTLE && settle_done && !rise && byte_cnt != '0) begin
                cfg_mapper <= cap_mapper;
                cfg_offset <= cap_offset;
                cfg_size   <= det_size;
                cfg_valid  <= 1'b1;
            end

            if (state == HOLD && hold_done && !rise) cart_reset <= 1'b0;

            if (restart) begin
                cart_reset  <= 1'b1;
                cfg_valid   <= 1'b0;
                err_overrun <= 1'b0;
                byte_cnt    <= '0;
                cnt         <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cart_load_ctrl.sv
// Directed bench for cart_load_ctrl: handshake timing, commit strobes, config capture, reset and overrun cases.
module tb_cart_load_ctrl;

    localparam logic [24:0] BASE = 25'h100000;
    localparam int          SC   = 4;
    localparam int          RH   = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_isROM = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        ioctl_wait;
    logic        mem_req;
    logic        mem_ack = 1'b0;
    logic [24:0] mem_addr;
    logic [7:0]  mem_din;
    logic        rom_we;
    logic [24:0] rom_addr;
    logic [7:0]  rom_dout;
    logic [2:0]  det_mapper = 3'd5;
    logic [3:0]  det_offset = 4'd4;
    logic [24:0] det_size = 25'h20000;
    logic [2:0]  ovr = 3'd0;
    logic [2:0]  cfg_mapper;
    logic [3:0]  cfg_offset;
    logic [24:0] cfg_size;
    logic        cfg_valid;
    logic        cart_reset;
    logic        err_overrun;

    int vectors = 0;
    int miscompares = 0;
    int we_count = 0;

    cart_load_ctrl #(.BASE_ADDR(BASE), .SETTLE_CYCLES(SC), .RESET_HOLD(RH)) dut (
        .clk(clk), .reset(reset),
        .ioctl_isROM(ioctl_isROM), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr), .mem_din(mem_din),
        .rom_we(rom_we), .rom_addr(rom_addr), .rom_dout(rom_dout),
        .det_mapper(det_mapper), .det_offset(det_offset), .det_size(det_size),
`ifdef CART_MAPPER_OVERRIDE_EN
        .override_mapper(ovr),
`endif
        .cfg_mapper(cfg_mapper), .cfg_offset(cfg_offset), .cfg_size(cfg_size),
        .cfg_valid(cfg_valid), .cart_reset(cart_reset), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rom_we === 1'b1) we_count++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        ioctl_isROM = 1'b1;
        tick();
        vectors++;
        if (cart_reset !== 1'b1 || cfg_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL start: cart_reset=%b cfg_valid=%b, need 1/0", cart_reset, cfg_valid);
        end
    endtask

    // one byte: strobe, check request, ack after dly cycles, check commit
    task automatic write_byte(input logic [24:0] a, input logic [7:0] d, input int dly, input bit drop_rom);
        ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        if (drop_rom) ioctl_isROM = 1'b0;
        vectors++;
        if (mem_req !== 1'b1 || ioctl_wait !== 1'b1 || mem_addr !== BASE + a || mem_din !== d) begin
            miscompares++;
            $display("FAIL req: req=%b wait=%b addr=%h din=%h, need 1/1/%h/%h", mem_req, ioctl_wait, mem_addr, mem_din, BASE + a, d);
        end
        for (int i = 0; i < dly; i++) begin
            tick();
            vectors++;
            if (mem_req !== 1'b1 || ioctl_wait !== mem_req || rom_we !== 1'b0) begin
                miscompares++;
                $display("FAIL pending: req=%b wait=%b we=%b, need 1/1/0", mem_req, ioctl_wait, rom_we);
            end
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        vectors++;
        if (mem_req !== 1'b0 || ioctl_wait !== 1'b0 || rom_we !== 1'b1 || rom_addr !== a || rom_dout !== d) begin
            miscompares++;
            $display("FAIL commit: req=%b wait=%b we=%b raddr=%h rdat=%h, need 0/0/1/%h/%h", mem_req, ioctl_wait, rom_we, rom_addr, rom_dout, a, d);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (cart_reset !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        vectors++;
        if (cart_reset !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_timeout: cart_reset=%b after %0d cycles, need 0", cart_reset, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        vectors++;
        if (mem_req !== 0 || ioctl_wait !== 0 || rom_we !== 0 || cart_reset !== 0 || cfg_valid !== 0 ||
            cfg_mapper !== 0 || cfg_offset !== 0 || cfg_size !== 0 || err_overrun !== 0 || mem_addr !== 0) begin
            miscompares++;
            $display("FAIL reset_state: req=%b wait=%b we=%b crst=%b cv=%b cm=%h co=%h cs=%h err=%b ma=%h, need all 0",
                     mem_req, ioctl_wait, rom_we, cart_reset, cfg_valid, cfg_mapper, cfg_offset, cfg_size, err_overrun, mem_addr);
        end
    endtask

    task automatic test_zero_byte();
        start_load();
        ioctl_isROM = 1'b0;
        tick();
        vectors++;
        if (cart_reset !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_hold: cart_reset=%b, need 1", cart_reset);
        end
        wait_idle();
        vectors++;
        if (cfg_valid !== 1'b0 || cfg_mapper !== 3'd0 || cfg_size !== 25'd0) begin
            miscompares++;
            $display("FAIL zero_cfg: valid=%b mapper=%h size=%h, need 0/0/0", cfg_valid, cfg_mapper, cfg_size);
        end
    endtask

    task automatic test_four_bytes();
        int base_we;
        base_we = we_count;
        start_load();
        for (int i = 0; i < 4; i++) write_byte(25'(i), 8'hA0 + 8'(i), 2, 1'b0);
        ioctl_isROM = 1'b0;
        tick();
        wait_idle();
        vectors++;
        if (we_count - base_we !== 4 || cfg_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL four_bytes: rom_we pulses=%0d valid=%b, need 4/1", we_count - base_we, cfg_valid);
        end
    endtask

    task automatic test_isrom_fall();
        start_load();
        write_byte(25'h10, 8'h11, 1, 1'b0);
        write_byte(25'h11, 8'h22, 0, 1'b0);
        write_byte(25'h12, 8'h33, 2, 1'b1);
        for (int k = 1; k <= SC; k++) begin
            tick();
            vectors++;
            if (cfg_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL settle_early: cycle %0d cfg_valid=%b, need 0", k, cfg_valid);
            end
        end
        tick();
        vectors++;
        if (cfg_valid !== 1'b1 || cfg_mapper !== 3'd5 || cfg_offset !== 4'd4 || cfg_size !== 25'h20000 || cart_reset !== 1'b1) begin
            miscompares++;
            $display("FAIL capture: valid=%b m=%h o=%h s=%h crst=%b, need 1/5/4/20000/1", cfg_valid, cfg_mapper, cfg_offset, cfg_size, cart_reset);
        end
        for (int k = 1; k < RH; k++) tick();
        vectors++;
        if (cart_reset !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_early: cart_reset=%b, need 1", cart_reset);
        end
        tick();
        vectors++;
        if (cart_reset !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_release: cart_reset=%b, need 0", cart_reset);
        end
    endtask

    task automatic test_overrun();
        start_load();
        ioctl_addr = 25'h40; ioctl_dout = 8'h5A; ioctl_wr = 1'b1;
        tick();
        ioctl_addr = 25'h41; ioctl_dout = 8'hC3;
        tick();
        ioctl_wr = 1'b0;
        vectors++;
        if (err_overrun !== 1'b1 || mem_addr !== BASE + 25'h40 || rom_addr !== 25'h40 || mem_din !== 8'h5A) begin
            miscompares++;
            $display("FAIL overrun: err=%b maddr=%h raddr=%h din=%h, need 1/%h/40/5a", err_overrun, mem_addr, rom_addr, mem_din, BASE + 25'h40);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick(); tick();
        vectors++;
        if (mem_req !== 1'b0 || rom_dout !== 8'h5A) begin
            miscompares++;
            $display("FAIL overrun_drop: req=%b rdat=%h, need 0/5a", mem_req, rom_dout);
        end
        ioctl_isROM = 1'b0;
        tick();
        wait_idle();
        vectors++;
        if (err_overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_sticky: err=%b, need 1", err_overrun);
        end
        start_load();
        vectors++;
        if (err_overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_clear: err=%b, need 0", err_overrun);
        end
        ioctl_isROM = 1'b0;
        tick();
        wait_idle();
    endtask

    task automatic test_override();
`ifdef CART_MAPPER_OVERRIDE_EN
        ovr = 3'd3; det_mapper = 3'd6; det_offset = 4'd8;
        start_load();
        write_byte(25'h0, 8'h77, 1, 1'b1);
        wait_idle();
        vectors++;
        if (cfg_mapper !== 3'd3 || cfg_offset !== 4'd0 || cfg_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL override: m=%h o=%h v=%b, need 3/0/1", cfg_mapper, cfg_offset, cfg_valid);
        end
        ovr = 3'd0; det_mapper = 3'd5; det_offset = 4'd4;
`endif
    endtask

    task automatic test_reset_mid_write();
        int base_we;
        start_load();
        ioctl_addr = 25'h7; ioctl_dout = 8'h99; ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        reset = 1'b1; ioctl_isROM = 1'b0;
        tick();
        reset = 1'b0;
        vectors++;
        if (mem_req !== 1'b0 || cart_reset !== 1'b0 || cfg_valid !== 1'b0 || ioctl_wait !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: req=%b crst=%b valid=%b wait=%b, need 0/0/0/0", mem_req, cart_reset, cfg_valid, ioctl_wait);
        end
        base_we = we_count;
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        vectors++;
        if (rom_we !== 1'b0 || we_count !== base_we || mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL late_ack: we=%b pulses=%0d req=%b, need 0/0/0", rom_we, we_count - base_we, mem_req);
        end
    endtask

    initial begin
        test_reset();
        test_zero_byte();
        test_four_bytes();
        test_isrom_fall();
        test_overrun();
        test_override();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
